// File: rtl/core_if_fetch_buf.sv
// Instruction-fetch stage: owns the PC, issues pipelined L1I requests and
// keeps the returned instructions, with their PCs, in an in-order buffer that
// decode drains. A redirect flushes the buffer and marks every response still
// in flight for the old stream to be discarded on arrival.
//
// Handshakes: every channel is valid/ready style. A transfer happens in a
// cycle exactly when the producer's valid and the consumer's accept
// (l1i_req_ack / dec_ready) are both high at the rising clk edge. Valid never
// depends combinationally on the accept of the same channel.
module core_if_fetch_buf #(
    parameter int              AW        = 32,
    parameter logic [AW-1:0]   PC_START  = 'h200,
    parameter int              BUF_DEPTH = 4
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          redir_val,
    input  logic [AW-1:0] redir_addr,
    output logic          l1i_req_val,
    output logic [AW-1:0] l1i_req_addr,
    input  logic          l1i_req_ack,
    input  logic          l1i_resp_val,
    input  logic [31:0]   l1i_resp_data,
    output logic          dec_val,
    output logic [31:0]   dec_instr,
    output logic [AW-1:0] dec_pc,
    output logic [AW-1:0] dec_pc_4,
    input  logic          dec_ready
);

    localparam int IW = $clog2(BUF_DEPTH);
    localparam int PW = IW + 1;

    // Architectural fetch PC and the buffer storage.
    logic [AW-1:0]        pc;
    logic [AW-1:0]        ent_pc    [BUF_DEPTH];
    logic [31:0]          ent_instr [BUF_DEPTH];
    logic [BUF_DEPTH-1:0] ent_filled;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] alloc;
    logic [PW-1:0] fill;
    logic [PW-1:0] rd;
    logic [PW-1:0] drop_cnt;

    logic [IW-1:0] alloc_idx;
    logic [IW-1:0] fill_idx;
    logic [IW-1:0] rd_idx;
    logic [PW-1:0] occupancy;
    logic [PW-1:0] unfilled;
    logic [PW:0]   in_use;
    logic          issue;
    logic          resp_drop;
    logic          resp_fill;
    logic          resp_used;
    logic          pop;
    logic          unused_low_bits;

    assign alloc_idx = alloc[IW-1:0];
    assign fill_idx  = fill[IW-1:0];
    assign rd_idx    = rd[IW-1:0];
    assign occupancy = alloc - rd;
    assign unfilled  = alloc - fill;

    // Stale in-flight responses still hold a buffer credit until they return.
    assign in_use      = {1'b0, occupancy} + {1'b0, drop_cnt};
    assign l1i_req_val = n_rst & ~redir_val & (in_use < (PW+1)'(BUF_DEPTH));
    assign l1i_req_addr = pc;
    assign issue       = l1i_req_val & l1i_req_ack;

    // Responses retire stale requests first; the rest fill the live stream.
    assign resp_drop = l1i_resp_val & (drop_cnt != '0);
    assign resp_fill = l1i_resp_val & (drop_cnt == '0) & (fill != alloc);
    assign resp_used = resp_drop | resp_fill;

    assign dec_val = ent_filled[rd_idx] & (rd != alloc);
    assign pop     = dec_val & dec_ready & ~redir_val;

    // The target is always word aligned; its low bits are not used.
    assign unused_low_bits = ^redir_addr[1:0];

    // Drive decode outputs only while an instruction is actually presented.
    always_comb begin
        dec_instr = '0;
        dec_pc    = '0;
        dec_pc_4  = '0;
        if (dec_val) begin
            dec_instr = ent_instr[rd_idx];
            dec_pc    = ent_pc[rd_idx];
            dec_pc_4  = ent_pc[rd_idx] + AW'(4);
        end
    end

    // Control state: PC, pointers, fill flags and the stale-response counter.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pc         <= PC_START;
            alloc      <= '0;
            fill       <= '0;
            rd         <= '0;
            drop_cnt   <= '0;
            ent_filled <= '0;
        end else if (redir_val) begin
            // Everything not yet filled becomes stale; a response arriving
            // this cycle already belongs to the old stream and is spent.
            pc         <= {redir_addr[AW-1:2], 2'b00};
            alloc      <= '0;
            fill       <= '0;
            rd         <= '0;
            ent_filled <= '0;
            drop_cnt   <= drop_cnt + unfilled - PW'(resp_used);
        end else begin
            if (issue) begin
                alloc                 <= alloc + PW'(1);
                pc                    <= pc + AW'(4);
                ent_filled[alloc_idx] <= 1'b0;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (resp_fill) begin
                fill                 <= fill + PW'(1);
                ent_filled[fill_idx] <= 1'b1;
            end
            if (pop) begin
                rd                 <= rd + PW'(1);
                ent_filled[rd_idx] <= 1'b0;
            end
        end
    end

    // Payload storage; needs no reset because fill flags qualify it.
    always_ff @(posedge clk) begin
        if (n_rst && !redir_val && issue) begin
            ent_pc[alloc_idx] <= pc;
        end
        if (n_rst && !redir_val && resp_fill) begin
            ent_instr[fill_idx] <= l1i_resp_data;
        end
    end

    // A response with nothing outstanding is a cache protocol violation.
    assert property (@(posedge clk) disable iff (!n_rst)
        l1i_resp_val |-> ((drop_cnt != '0) || (fill != alloc)));

endmodule

// File: tb/tb_core_if_fetch_buf.sv
// Bench for core_if_fetch_buf. The reference model tracks fetch streams by
// epoch: every accepted request is tagged with the epoch current at issue, a
// redirect or reset opens a new epoch, and only responses from the current
// epoch become visible to decode, in issue order.
module tb_core_if_fetch_buf;

    localparam int            AW    = 16;
    localparam int            DEPTH = 4;
    localparam logic [AW-1:0] PC0   = 16'h0200;
    localparam int            EW    = AW + 32;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          redir_val = 1'b0;
    logic [AW-1:0] redir_addr = '0;
    logic          l1i_req_val;
    logic [AW-1:0] l1i_req_addr;
    logic          l1i_req_ack = 1'b0;
    logic          l1i_resp_val = 1'b0;
    logic [31:0]   l1i_resp_data = '0;
    logic          dec_val;
    logic [31:0]   dec_instr;
    logic [AW-1:0] dec_pc;
    logic [AW-1:0] dec_pc_4;
    logic          dec_ready = 1'b0;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        int            epoch;
    } req_t;

    req_t          pend_q[$];   // requests the cache has accepted, not yet answered
    logic [EW-1:0] exp_q[$];    // {pc, instr} visible to decode, in order
    logic [AW-1:0] model_pc = PC0;
    int            epoch = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_issue = 0;
    int            cyc = 0;
    bit            seen_rst = 1'b0;
    bit            lat_mode = 1'b0;

    // Clock and reset
    always #5 clk = ~clk;

    core_if_fetch_buf #(.AW(AW), .PC_START(PC0), .BUF_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .redir_val     (redir_val),
        .redir_addr    (redir_addr),
        .l1i_req_val   (l1i_req_val),
        .l1i_req_addr  (l1i_req_addr),
        .l1i_req_ack   (l1i_req_ack),
        .l1i_resp_val  (l1i_resp_val),
        .l1i_resp_data (l1i_resp_data),
        .dec_val       (dec_val),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .dec_pc_4      (dec_pc_4),
        .dec_ready     (dec_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Driver: one call drives one clock cycle of inputs.
    task automatic step(input bit rst, input bit rv, input logic [AW-1:0] ra,
                        input bit ak, input bit rs, input bit rdy);
        @(posedge clk);
        #1;
        n_rst       = !rst;
        redir_val   = rv;
        redir_addr  = ra;
        l1i_req_ack = ak;
        l1i_resp_val = rs && !rst && (pend_q.size() != 0);
        l1i_resp_data = (pend_q.size() != 0) ? pend_q[0].instr : $urandom;
        dec_ready   = rdy;
    endtask

    task automatic reset_dut();
        step(1, 0, '0, 0, 0, 0);
        step(1, 0, '0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    // Monitor and scoreboard: compare, then apply this cycle's events.
    always @(negedge clk) begin : monitor
        logic          exp_req;
        logic [EW-1:0] f;
        logic [AW-1:0] p4;
        req_t          r;
        exp_req = n_rst && !redir_val && ((exp_q.size() + pend_q.size()) < DEPTH);
        chk("req_val", 64'(l1i_req_val), 64'(exp_req));
        if (l1i_req_val && exp_req) chk("req_addr", 64'(l1i_req_addr), 64'(model_pc));
        if (n_rst) cyc++;
        if (lat_mode && n_rst && cyc <= 20) chk("lat_dec_val", 64'(dec_val), 64'(cyc >= 3));
        if (seen_rst) begin
            chk("dec_val", 64'(dec_val), 64'(exp_q.size() != 0));
            if (dec_val && exp_q.size() != 0) begin
                f  = exp_q[0];
                p4 = f[EW-1:32] + 16'd4;
                chk("dec_pc", 64'(dec_pc), 64'(f[EW-1:32]));
                chk("dec_instr", 64'(dec_instr), 64'(f[31:0]));
                chk("dec_pc_4", 64'(dec_pc_4), 64'(p4));
            end else if (!dec_val) begin
                chk("dec_idle_zero", {dec_instr, dec_pc, dec_pc_4}, 64'd0);
            end
        end
        if (!n_rst) begin
            // The cache is reset together with the fetch stage.
            pend_q.delete();
            exp_q.delete();
            model_pc = PC0;
            epoch++;
            cyc = 0;
            seen_rst = 1'b1;
        end else begin
            if (dec_ready && !redir_val && exp_q.size() != 0) void'(exp_q.pop_front());
            if (l1i_resp_val && pend_q.size() != 0) begin
                r = pend_q.pop_front();
                if (r.epoch == epoch) exp_q.push_back({r.pc, r.instr});
            end
            if (l1i_req_val && l1i_req_ack) begin
                r.pc    = model_pc;
                r.instr = $urandom;
                r.epoch = epoch;
                pend_q.push_back(r);
                model_pc = model_pc + 16'd4;
                n_issue++;
            end
            if (redir_val) begin
                model_pc = {redir_addr[AW-1:2], 2'b00};
                epoch++;
                exp_q.delete();
            end
        end
    end

    // Stimulus sequence and final report
    initial begin : driver
        int n0;
        reset_dut();

        // Full-speed streaming: first decode at cycle 3, then one per cycle.
        lat_mode = 1'b1;
        repeat (25) step(0, 0, '0, 1, 1, 1);
        lat_mode = 1'b0;

        // Decode stalled: buffer fills after exactly DEPTH requests.
        reset_dut();
        n0 = n_issue;
        repeat (12) step(0, 0, '0, 1, 1, 0);
        settle();
        chk("stall_issue_count", 64'(n_issue - n0), 64'(DEPTH));
        chk("stall_req_low", 64'(l1i_req_val), 64'd0);
        step(0, 0, '0, 1, 1, 1);
        step(0, 0, '0, 1, 1, 0);
        settle();
        chk("pop_reenable_val", 64'(l1i_req_val), 64'd1);
        chk("pop_reenable_addr", 64'(l1i_req_addr), 64'h210);
        repeat (10) step(0, 0, '0, 1, 1, 1);

        // Redirect with three requests outstanding.
        reset_dut();
        repeat (3) step(0, 0, '0, 1, 0, 1);
        step(0, 1, 16'h1001, 1, 0, 1);
        step(0, 0, '0, 1, 0, 1);
        settle();
        chk("redir_addr", 64'(l1i_req_addr), 64'h1000);
        chk("redir_drop_cnt", 64'(dut.drop_cnt), 64'd3);
        repeat (15) step(0, 0, '0, 1, 1, 1);

        // Redirect coinciding with a live response and a pop.
        reset_dut();
        repeat (3) step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 1, 16'h3000, 0, 1, 1);
        step(0, 0, '0, 0, 0, 0);
        settle();
        chk("same_cycle_drop_cnt", 64'(dut.drop_cnt), 64'd1);
        repeat (12) step(0, 0, '0, 1, 1, 1);

        // Address wrap at the top of the AW space.
        reset_dut();
        step(0, 1, 16'hFFFC, 1, 1, 1);
        step(0, 0, '0, 1, 1, 1);
        settle();
        chk("wrap_first", 64'(l1i_req_addr), 64'hFFFC);
        step(0, 0, '0, 1, 1, 1);
        settle();
        chk("wrap_second", 64'(l1i_req_addr), 64'h0000);
        repeat (10) step(0, 0, '0, 1, 1, 1);

        // Reset with two buffered entries and one request outstanding.
        reset_dut();
        repeat (3) step(0, 0, '0, 1, 1, 0);
        step(1, 0, '0, 1, 0, 1);
        step(1, 0, '0, 1, 0, 1);
        settle();
        chk("rst_dec_val", 64'(dec_val), 64'd0);
        chk("rst_req_val", 64'(l1i_req_val), 64'd0);
        step(0, 0, '0, 1, 1, 1);
        settle();
        chk("rst_first_addr", 64'(l1i_req_addr), 64'h200);

        // Randomized traffic with occasional redirects and resets.
        repeat (3000) begin
            step(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 19) == 0),
                 AW'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end
        repeat (20) step(0, 0, '0, 1, 1, 1);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
